// File: rtl/pic_host_pkg.sv
// Shared types and 8259 command-word bit fields for the PIC host sequencer.
package pic_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1,
    S_READY, S_INTA1, S_GAP, S_INTA2, S_DELIVER, S_EOI
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_SETUP, W_STROBE, W_HOLD
  } wr_phase_t;

  localparam logic [7:0] ICW1_D4     = 8'h10;
  localparam logic [7:0] ICW1_LTIM   = 8'h08;
  localparam logic [7:0] ICW1_SNGL   = 8'h02;
  localparam logic [7:0] ICW1_IC4    = 8'h01;
  localparam logic [7:0] ICW4_UPM    = 8'h01;
  localparam logic [7:0] ICW4_AEOI   = 8'h02;
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  // States in which the PIC is programmed and interrupts may be serviced.
  function automatic logic post_init(input state_t s);
    return (s == S_READY) || (s == S_INTA1) || (s == S_GAP) ||
           (s == S_INTA2) || (s == S_DELIVER) || (s == S_EOI);
  endfunction

endpackage

// File: rtl/pic_host_sequencer_bus_writer.sv
// Single 8259 bus write: setup, WR_PULSE-cycle strobe, hold. Module pic_bus_writer.
module pic_bus_writer
  import pic_host_pkg::*;
#(
  parameter int WR_PULSE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       a0_in,
  input  logic [7:0] data_in,
  output logic       done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       data_oe,
  output logic       a0_out,
  output logic [7:0] data_out,
  output wr_phase_t  phase_dbg
);

  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  wr_phase_t  phase_q;
  logic [7:0] cnt_q;
  logic       cs_n_q, wr_n_q, data_oe_q, a0_q, done_q;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= W_IDLE;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      a0_q      <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (phase_q)
        W_IDLE: begin
          if (go) begin
            phase_q   <= W_SETUP;
            cs_n_q    <= 1'b0;
            data_oe_q <= 1'b1;
            a0_q      <= a0_in;
            data_q    <= data_in;
          end
        end
        W_SETUP: begin
          phase_q <= W_STROBE;
          wr_n_q  <= 1'b0;
          cnt_q   <= WR_LAST;
        end
        W_STROBE: begin
          // done is raised during HOLD so the caller can queue the next word.
          if (cnt_q == '0) begin
            phase_q <= W_HOLD;
            wr_n_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        W_HOLD: begin
          phase_q   <= W_IDLE;
          cs_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
        end
        default: phase_q <= W_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign data_oe   = data_oe_q;
  assign a0_out    = a0_q;
  assign data_out  = data_q;
  assign phase_dbg = phase_q;

endmodule

// File: rtl/pic_host_sequencer.sv
// CPU-side 8259 driver: init ICW/OCW sequence, two-pulse INTA, vector capture, EOI.
// Optional AUTO_EOI_EN: program AEOI in ICW4 and never write OCW2.
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter int         SNGL        = 1,
  parameter int         LTIM        = 0,
  parameter logic [7:0] VECTOR_BASE = 8'h08,
  parameter logic [7:0] CASCADE_MAP = 8'h00,
  parameter logic [7:0] INIT_MASK   = 8'h00,
  parameter int         WR_PULSE    = 2,
  parameter int         INTA_PULSE  = 2,
  parameter int         INTA_GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_init,
  output logic       init_done,
  output logic       busy,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       int_in,
  output logic       inta_n,
  output logic       vector_valid,
  output logic [7:0] vector,
  input  logic       eoi_req,
  output state_t     state_dbg,
  output wr_phase_t  wr_phase_dbg
);

  localparam logic [7:0] INTA_LAST = 8'(INTA_PULSE - 1);
  localparam logic [7:0] GAP_LAST  = 8'(INTA_GAP - 1);

  localparam logic [7:0] ICW1_WORD = ICW1_D4 | ICW1_IC4 |
                                     ((LTIM != 0) ? ICW1_LTIM : 8'h00) |
                                     ((SNGL != 0) ? ICW1_SNGL : 8'h00);
  localparam logic [7:0] ICW2_WORD = {VECTOR_BASE[7:3], 3'b000};
`ifdef AUTO_EOI_EN
  localparam logic [7:0] ICW4_WORD = ICW4_AEOI | ICW4_UPM;
`else
  localparam logic [7:0] ICW4_WORD = ICW4_UPM;
`endif

  // {a0, data} written on entry to each bus-write state.
  function automatic logic [8:0] wr_word(input state_t s);
    case (s)
      S_ICW1:  wr_word = {1'b0, ICW1_WORD};
      S_ICW2:  wr_word = {1'b1, ICW2_WORD};
      S_ICW3:  wr_word = {1'b1, CASCADE_MAP};
      S_ICW4:  wr_word = {1'b1, ICW4_WORD};
      S_OCW1:  wr_word = {1'b1, INIT_MASK};
      S_EOI:   wr_word = {1'b0, OCW2_NS_EOI};
      default: wr_word = 9'h000;
    endcase
  endfunction

  state_t     state_q, wr_next;
  logic [7:0] cnt_q, vector_q;
  logic [8:0] wr_word_q;
  logic       wr_go_q, inta_n_q, vector_valid_q, eoi_pending_q, wr_done;

  always_comb begin
    wr_next = S_READY;
    case (state_q)
      S_ICW1:  wr_next = S_ICW2;
      S_ICW2:  wr_next = (SNGL != 0) ? S_ICW4 : S_ICW3;
      S_ICW3:  wr_next = S_ICW4;
      S_ICW4:  wr_next = S_OCW1;
      default: wr_next = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      vector_q       <= '0;
      wr_word_q      <= '0;
      wr_go_q        <= 1'b0;
      inta_n_q       <= 1'b1;
      vector_valid_q <= 1'b0;
      eoi_pending_q  <= 1'b0;
    end else begin
      wr_go_q        <= 1'b0;
      vector_valid_q <= 1'b0;
`ifndef AUTO_EOI_EN
      if (eoi_req && post_init(state_q)) eoi_pending_q <= 1'b1;
`endif
      case (state_q)
        S_IDLE: begin
          if (start_init) begin
            state_q   <= S_ICW1;
            wr_go_q   <= 1'b1;
            wr_word_q <= wr_word(S_ICW1);
          end
        end
        S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1: begin
          if (wr_done) begin
            state_q <= wr_next;
            if (wr_next != S_READY) begin
              wr_go_q   <= 1'b1;
              wr_word_q <= wr_word(wr_next);
            end
          end
        end
        S_READY: begin
`ifndef AUTO_EOI_EN
          if (eoi_pending_q) begin
            state_q   <= S_EOI;
            wr_go_q   <= 1'b1;
            wr_word_q <= wr_word(S_EOI);
          end else
`endif
          if (int_in) begin
            state_q  <= S_INTA1;
            inta_n_q <= 1'b0;
            cnt_q    <= INTA_LAST;
          end else if (start_init) begin
            state_q   <= S_ICW1;
            wr_go_q   <= 1'b1;
            wr_word_q <= wr_word(S_ICW1);
          end
        end
        S_INTA1: begin
          // Once INTA1 starts the cycle completes even if int_in drops.
          if (cnt_q == '0) begin
            state_q  <= S_GAP;
            inta_n_q <= 1'b1;
            cnt_q    <= GAP_LAST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q  <= S_INTA2;
            inta_n_q <= 1'b0;
            cnt_q    <= INTA_LAST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_INTA2: begin
          if (cnt_q == '0) begin
            state_q        <= S_DELIVER;
            inta_n_q       <= 1'b1;
            vector_q       <= data_in;
            vector_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DELIVER: begin
`ifndef AUTO_EOI_EN
          if (eoi_pending_q) begin
            state_q   <= S_EOI;
            wr_go_q   <= 1'b1;
            wr_word_q <= wr_word(S_EOI);
          end else
`endif
          state_q <= S_READY;
        end
`ifndef AUTO_EOI_EN
        S_EOI: begin
          if (wr_done) begin
            state_q       <= S_READY;
            eoi_pending_q <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AUTO_EOI_EN
  logic unused_eoi;
  assign unused_eoi = eoi_req ^ eoi_pending_q;
`endif

  pic_bus_writer #(
    .WR_PULSE(WR_PULSE)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .go       (wr_go_q),
    .a0_in    (wr_word_q[8]),
    .data_in  (wr_word_q[7:0]),
    .done     (wr_done),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .data_oe  (data_oe),
    .a0_out   (a0),
    .data_out (data_out),
    .phase_dbg(wr_phase_dbg)
  );

  assign rd_n         = 1'b1;
  assign inta_n       = inta_n_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign init_done    = post_init(state_q);
  assign busy         = !((state_q == S_IDLE) || (state_q == S_READY));
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: single and cascade init, INTA, EOI, reset abort.
`timescale 1ns/1ps
module tb_pic_host_sequencer;
  import pic_host_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start_init = 1'b0, int_in = 1'b0, eoi_req = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       start_init_b = 1'b0;

  logic       init_done, busy, cs_n, wr_n, rd_n, a0, data_oe, inta_n, vector_valid;
  logic [7:0] data_out, vector;
  state_t     state_dbg;
  wr_phase_t  wr_phase_dbg;

  logic       b_init_done, b_busy, b_cs_n, b_wr_n, b_rd_n, b_a0, b_data_oe, b_inta_n, b_vv;
  logic [7:0] b_data_out, b_vector;
  state_t     b_state;
  wr_phase_t  b_wr_phase;

`ifdef AUTO_EOI_EN
  localparam logic [7:0] EXP_ICW4 = 8'h03;
  localparam int         EXP_EOI_WRITES = 0;
`else
  localparam logic [7:0] EXP_ICW4 = 8'h01;
  localparam int         EXP_EOI_WRITES = 1;
`endif

  pic_host_sequencer dut (
    .clk(clk), .rst(rst), .start_init(start_init), .init_done(init_done), .busy(busy),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .int_in(int_in), .inta_n(inta_n), .vector_valid(vector_valid),
    .vector(vector), .eoi_req(eoi_req), .state_dbg(state_dbg), .wr_phase_dbg(wr_phase_dbg)
  );

  pic_host_sequencer #(.SNGL(0), .CASCADE_MAP(8'h04)) dut_b (
    .clk(clk), .rst(rst), .start_init(start_init_b), .init_done(b_init_done), .busy(b_busy),
    .cs_n(b_cs_n), .wr_n(b_wr_n), .rd_n(b_rd_n), .a0(b_a0), .data_out(b_data_out),
    .data_oe(b_data_oe), .data_in(8'h00), .int_in(1'b0), .inta_n(b_inta_n),
    .vector_valid(b_vv), .vector(b_vector), .eoi_req(1'b0), .state_dbg(b_state),
    .wr_phase_dbg(b_wr_phase)
  );

  // Scoreboard
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_a_q[$], obs_b_q[$];
  int         len_a_q[$], len_b_q[$];
  int         low_a = 0, low_b = 0;

  // Bus monitors: record {a0,data} and wr_n low length at each completed strobe.
  always @(negedge clk) begin
    if (rst) low_a = 0;
    else if (!wr_n) low_a++;
    else if (low_a != 0) begin
      obs_a_q.push_back({a0, data_out});
      len_a_q.push_back(low_a);
      low_a = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) low_b = 0;
    else if (!b_wr_n) low_b++;
    else if (low_b != 0) begin
      obs_b_q.push_back({b_a0, b_data_out});
      len_b_q.push_back(low_b);
      low_b = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic pulse_start();
    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
  endtask

  task automatic wait_init_done(input string name);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: init_done=%b after %0d cycles, expected 1", name, init_done, n);
    end
  endtask

  // Follows one INTA cycle from READY, dropping int_in once INTA1 starts.
  task automatic measure_inta(input bit do_eoi, output int lead, output int lo1,
                              output int gap, output int lo2, output bit got,
                              output logic [7:0] vec);
    int phase, s;
    phase = 0; s = 0; lead = 0; lo1 = 0; gap = 0; lo2 = 0; got = 1'b0; vec = 8'hxx;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (vector_valid) begin
        got = 1'b1;
        vec = vector;
      end
      if (phase != 0) begin
        s++;
        if (s == 1 || s == 3) eoi_req = 1'b0;
        if (s == 2) eoi_req = do_eoi;
      end
      case (phase)
        0: if (!inta_n) begin phase = 1; lo1 = 1; int_in = 1'b0; eoi_req = do_eoi; end
           else lead++;
        1: if (!inta_n) lo1++; else begin phase = 2; gap = 1; end
        2: if (inta_n) gap++; else begin phase = 3; lo2 = 1; end
        3: if (!inta_n) lo2++; else phase = 4;
        default: ;
      endcase
    end
    eoi_req = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({cs_n, wr_n, rd_n, inta_n, a0, data_oe, vector_valid, init_done, busy} !== 9'b111100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 111100000",
               {cs_n, wr_n, rd_n, inta_n, a0, data_oe, vector_valid, init_done, busy});
    end
    tests_run++;
    if (data_out !== 8'h00 || vector !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: data_out=%h vector=%h expected 00 00", data_out, vector);
    end
    tests_run++;
    if (state_dbg !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_single();
    obs_a_q.delete(); len_a_q.delete();
    eoi_req = 1'b1; @(negedge clk); eoi_req = 1'b0;
    int_in = 1'b0;
    pulse_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_busy: busy=%b expected 1", busy);
    end
    repeat (3) @(negedge clk);
    pulse_start();
    eoi_req = 1'b1; @(negedge clk); eoi_req = 1'b0;
    wait_init_done("init_single_done");
    repeat (12) @(negedge clk);
    exp_q = '{9'h013, 9'h108, {1'b1, EXP_ICW4}, 9'h100};
    tests_run++;
    if (obs_a_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL init_single_count: got %0d writes expected %0d", obs_a_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a_q.size(); i++) begin
      tests_run++;
      if (obs_a_q[i] !== exp_q[i] || len_a_q[i] != 2) begin
        tests_failed++;
        $display("FAIL init_single_w%0d: got a0/data %h len %0d expected %h len 2",
                 i, obs_a_q[i], len_a_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || state_dbg !== S_READY) begin
      tests_failed++;
      $display("FAIL init_single_ready: busy=%b state=%0d expected 0 %0d", busy, state_dbg, S_READY);
    end
  endtask

  task automatic test_init_cascade();
    int n;
    obs_b_q.delete(); len_b_q.delete();
    start_init_b = 1'b1; @(negedge clk); start_init_b = 1'b0;
    n = 0;
    while (!b_init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (b_init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL cascade_done: init_done=%b expected 1", b_init_done);
    end
    repeat (5) @(negedge clk);
    exp_q = '{9'h011, 9'h108, 9'h104, {1'b1, EXP_ICW4}, 9'h100};
    tests_run++;
    if (obs_b_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL cascade_count: got %0d writes expected %0d", obs_b_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_b_q.size(); i++) begin
      tests_run++;
      if (obs_b_q[i] !== exp_q[i] || len_b_q[i] != 2) begin
        tests_failed++;
        $display("FAIL cascade_w%0d: got a0/data %h len %0d expected %h len 2",
                 i, obs_b_q[i], len_b_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_interrupt();
    int lead, lo1, gap, lo2; bit got; logic [7:0] vec;
    obs_a_q.delete(); len_a_q.delete();
    data_in = 8'h0D;
    int_in = 1'b1;
    measure_inta(1'b0, lead, lo1, gap, lo2, got, vec);
    tests_run++;
    if (lead != 0 || lo1 != 2 || gap != 2 || lo2 != 2) begin
      tests_failed++;
      $display("FAIL inta_timing: lead=%0d lo1=%0d gap=%0d lo2=%0d expected 0 2 2 2", lead, lo1, gap, lo2);
    end
    tests_run++;
    if (!got || vec !== 8'h0D) begin
      tests_failed++;
      $display("FAIL inta_vector: valid=%b vector=%h expected 1 0d", got, vec);
    end
    @(negedge clk);
    tests_run++;
    if (vector_valid !== 1'b0 || vector !== 8'h0D) begin
      tests_failed++;
      $display("FAIL inta_pulse: vector_valid=%b vector=%h expected 0 0d", vector_valid, vector);
    end
    repeat (15) @(negedge clk);
    tests_run++;
    if (obs_a_q.size() != 0 || busy !== 1'b0 || inta_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL inta_quiet: writes=%0d busy=%b inta_n=%b expected 0 0 1", obs_a_q.size(), busy, inta_n);
    end
  endtask

  task automatic test_eoi();
    int lead, lo1, gap, lo2; bit got; logic [7:0] vec;
    obs_a_q.delete(); len_a_q.delete();
    data_in = 8'h21;
    int_in = 1'b1;
    measure_inta(1'b1, lead, lo1, gap, lo2, got, vec);
    tests_run++;
    if (!got || vec !== 8'h21) begin
      tests_failed++;
      $display("FAIL eoi_vector: valid=%b vector=%h expected 1 21", got, vec);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (obs_a_q.size() != EXP_EOI_WRITES) begin
      tests_failed++;
      $display("FAIL eoi_count: got %0d writes expected %0d", obs_a_q.size(), EXP_EOI_WRITES);
    end
    if (EXP_EOI_WRITES == 1 && obs_a_q.size() >= 1) begin
      tests_run++;
      if (obs_a_q[0] !== 9'h020 || len_a_q[0] != 2) begin
        tests_failed++;
        $display("FAIL eoi_word: got a0/data %h len %0d expected 020 len 2", obs_a_q[0], len_a_q[0]);
      end
    end
    tests_run++;
    if (state_dbg !== S_READY || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL eoi_ready: state=%0d busy=%b expected %0d 0", state_dbg, busy, S_READY);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    pulse_start();
    n = 0;
    while (!(wr_n === 1'b0 && a0 === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!(wr_n === 1'b0 && a0 === 1'b1 && data_out === 8'h08)) begin
      tests_failed++;
      $display("FAIL abort_reach_icw2: wr_n=%b a0=%b data=%h expected 0 1 08", wr_n, a0, data_out);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({wr_n, cs_n, data_oe, init_done, busy} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL abort_strobes: wr_n/cs_n/oe/done/busy=%b expected 11000",
               {wr_n, cs_n, data_oe, init_done, busy});
    end
    tests_run++;
    if (state_dbg !== S_IDLE) begin
      tests_failed++;
      $display("FAIL abort_state: got %0d expected %0d", state_dbg, S_IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
    obs_a_q.delete(); len_a_q.delete();
  endtask

  task automatic test_int_before_init();
    int lead, lo1, gap, lo2; bit got; logic [7:0] vec; bit early; int n;
    early = 1'b0;
    data_in = 8'h0F;
    int_in = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (inta_n !== 1'b1) early = 1'b1;
    end
    pulse_start();
    n = 0;
    while (!init_done && n < 100) begin
      if (inta_n !== 1'b1) early = 1'b1;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (early || init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_inta: early=%b init_done=%b expected 0 1", early, init_done);
    end
    obs_a_q.delete(); len_a_q.delete();
    measure_inta(1'b0, lead, lo1, gap, lo2, got, vec);
    tests_run++;
    if (lead != 0) begin
      tests_failed++;
      $display("FAIL late_inta_start: lead=%0d cycles expected 0", lead);
    end
    tests_run++;
    if (!got || vec !== 8'h0F || lo1 != 2 || lo2 != 2) begin
      tests_failed++;
      $display("FAIL late_inta_vector: valid=%b vector=%h lo1=%0d lo2=%0d expected 1 0f 2 2",
               got, vec, lo1, lo2);
    end
    repeat (15) @(negedge clk);
    tests_run++;
    if (obs_a_q.size() != 0) begin
      tests_failed++;
      $display("FAIL late_inta_writes: got %0d writes expected 0", obs_a_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_init_single();
    test_init_cascade();
    test_interrupt();
    test_eoi();
    test_reset_mid_write();
    test_int_before_init();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
